mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache and data-cache miss paths.
- Sits between both cache controllers and the memory model in the pipeline CPU top level.
- Round-robin arbitration, one outstanding transaction at a time, with a wait-timeout guard that reports an error if memory never answers.
- Each cache raises a request on a miss and stalls the pipeline until the arbiter pulses its done.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, maximum WAIT cycles before an access is aborted; must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- i_req  in  1  I-side request; held until i_done
- i_addr  in  ADDR_W  I-side address
- i_wr  in  1  I-side write flag
- i_wdata  in  DATA_W  I-side write data
- i_rdata  out  DATA_W  I-side read data; valid when i_done=1
- i_done  out  1  one-cycle completion pulse, I side
- d_req, d_addr, d_wr, d_wdata, d_rdata, d_done  same as the I-side ports, D side
- mem_req  out  1  memory access active
- mem_addr  out  ADDR_W  latched address
- mem_wr  out  1  latched write flag
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse
- err  out  1  sticky timeout flag

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs are 0; state=IDLE; last_grant=I, so D wins the first tie; timer=0; all latch registers are 0.
- Reset asserted mid-operation returns the block to IDLE immediately and drops mem_req. Any in-flight transaction is discarded with no done pulse.
- All outputs are registered.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester active: grant it.
  - Both active: grant the side not equal to last_grant.
  - On grant, latch owner, addr, wr and wdata into mem_* registers, set mem_req=1, clear the timer, update last_grant, go to WAIT.
  - No request: stay in IDLE.
- WAIT:
  - mem_req stays 1 and mem_addr/mem_wr/mem_wdata are held stable.
  - mem_ready=1: on a read, load mem_rdata into the owner's rdata register. Clear mem_req, go to DONE.
  - Otherwise, if timer == TIMEOUT-1: owner's rdata := 0 on a read, set err=1, clear mem_req, go to DONE.
  - Otherwise, timer increments. Timer width is clog2(TIMEOUT).
- DONE:
  - The owner's done output is 1 for exactly this cycle; the other side's done stays 0.
  - Next state is IDLE.
  - The requester must deassert req in the cycle after it sees done. Because req is sampled only in IDLE, the finished request is never re-granted.
- Write data and rdata:
  - On a write, the owner's rdata is left unchanged.
  - Each rdata register holds its value until that side's next read completes.
- Latency: req high in cycle 0 → mem_req high from cycle 1 → mem_ready in cycle 1 gives done in cycle 2. Minimum is 2 cycles; in general latency = 2 + extra WAIT cycles.
- Ignored inputs:
  - mem_ready in IDLE or DONE is ignored.
  - Request-side field changes during WAIT are ignored, because fields are latched.
- err is sticky: it is set on any timeout and cleared only by reset. A timeout does not block later transactions.
- Fairness: with both requests held continuously, grants strictly alternate D, I, D, I.

Decomposition:
- mem_arb_pkg:
  - state_t enum {IDLE, WAIT, DONE}
  - owner_t enum {OWN_I, OWN_D}
  - default-width localparams ADDR_W_DEF / DATA_W_DEF
- Sub-module mem_arb_timer:
  - Parametrised TIMEOUT counter with clear/enable inputs and an expire output.
  - Same clk/reset convention as mem_arbiter.
- The remainder stays flat in mem_arbiter.

Test Plan:
- Single I read: i_req=1, i_addr=0x40, memory returns 0xDEADBEEF with mem_ready 3 cycles after mem_req rises → mem_addr=0x40 and mem_wr=0 throughout WAIT; i_rdata=0xDEADBEEF with i_done=1 in the cycle after mem_ready; d_done stays 0; total latency 5 cycles.
- Simultaneous requests right after reset: i_req=d_req=1 held, fixed 1-cycle memory → D granted first (d_addr on mem_addr). Then I, then D, strictly alternating; each done is a single pulse.
- D write: d_req=1, d_wr=1, d_addr=0x100, d_wdata=0x12345678 → mem_wr=1 and mem_wdata=0x12345678 held until mem_ready; d_done pulses; d_rdata keeps its previous value.
- Timeout: TIMEOUT=8, i_req read, mem_ready never asserted → mem_req high for exactly 8 cycles; i_done=1 with i_rdata=0; err=1 and remains 1. A following D read with a normal memory response completes correctly with err still 1.
- Reset mid-WAIT: assert reset asynchronously (between clock edges) during WAIT → mem_req=0 and state=IDLE without waiting for a clock edge; no done pulse. After release, a new d_req gets D first; last_grant was reset to I.
- Stray mem_ready pulse in IDLE → no state change, no done, rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter: expire_o is high while the count sits at TIMEOUT-1.
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache
// miss paths, one transaction at a time, with a sticky wait-timeout error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output state_t            state_o
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, last_grant_q, last_grant_d, grant;
    logic              mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
    logic              expire, finish;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != WAIT),
        .en_i     ((state_q == WAIT) && !mem_ready && !expire),
        .expire_o (expire)
    );

    assign finish = (state_q == WAIT) && (mem_ready || expire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = WAIT;
            WAIT:    if (mem_ready || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A tie goes to whichever side did not win the previous grant.
    always_comb begin
        grant        = (i_req && d_req) ? ((last_grant_q == OWN_I) ? OWN_D : OWN_I)
                                        : (d_req ? OWN_D : OWN_I);
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_d     = mem_wr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        err_d        = err_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            owner_d      = grant;
            last_grant_d = grant;
            mem_req_d    = 1'b1;
            mem_addr_d   = (grant == OWN_D) ? d_addr  : i_addr;
            mem_wr_d     = (grant == OWN_D) ? d_wr    : i_wr;
            mem_wdata_d  = (grant == OWN_D) ? d_wdata : i_wdata;
        end
        if (finish) begin
            mem_req_d = 1'b0;
            if (!mem_ready) err_d = 1'b1;
            if (!mem_wr_q && owner_q == OWN_I) i_rdata_d = mem_ready ? mem_rdata : '0;
            if (!mem_wr_q && owner_q == OWN_D) d_rdata_d = mem_ready ? mem_rdata : '0;
            i_done_d = (owner_q == OWN_I);
            d_done_d = (owner_q == OWN_D);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, read data and the sticky error.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_wr, d_req, d_wr, mem_ready;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic          i_done, d_done, mem_req, mem_wr, err;
    state_t        state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who won last, each side's visible read data, error flag.
    bit            m_last_d;
    logic [DW-1:0] m_i_rdata, m_d_rdata;
    bit            m_err;
    logic [DW-1:0] exp_q[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_wr(i_wr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_d  = 1'b0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_err     = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        i_req = 0; d_req = 0; i_wr = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_done"}, 32'({i_done, d_done}), 32'd0);
        check({tag, "_i_rdata"}, i_rdata, m_i_rdata);
        check({tag, "_d_rdata"}, d_rdata, m_d_rdata);
        check({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    // Requests must already be set up before this is called, in IDLE at a negedge.
    task automatic txn(input int delay, input bit to, input logic [DW-1:0] rdat, input bit hold);
        bit            own_d;
        logic [AW-1:0] e_addr;
        bit            e_wr;
        logic [DW-1:0] e_wdata;
        int            cyc, last_wait;
        own_d    = (i_req && d_req) ? !m_last_d : d_req;
        m_last_d = own_d;
        e_addr   = own_d ? d_addr : i_addr;
        e_wr     = own_d ? d_wr : i_wr;
        e_wdata  = own_d ? d_wdata : i_wdata;
        if (!e_wr) begin
            if (own_d) m_d_rdata = to ? '0 : rdat;
            else       m_i_rdata = to ? '0 : rdat;
        end
        if (to) m_err = 1'b1;
        exp_q.push_back(own_d ? m_d_rdata : m_i_rdata);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_req && cyc < 4);
        check("grant_latency", 32'(cyc), 32'd1);

        last_wait = to ? TO : 1 + delay;
        for (int c = 1; c <= last_wait; c++) begin
            if (c > 1) @(negedge clk);
            check("wait_mem_req", 32'(mem_req), 32'd1);
            check("wait_mem_addr", mem_addr, e_addr);
            check("wait_mem_wr", 32'(mem_wr), 32'(e_wr));
            check("wait_mem_wdata", mem_wdata, e_wdata);
            check("wait_no_done", 32'({i_done, d_done}), 32'd0);
            if (!to && c == last_wait) begin
                mem_ready = 1'b1;
                mem_rdata = rdat;
            end else if (own_d) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else begin
                i_addr  = $urandom;
                i_wdata = $urandom;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        check(own_d ? "owner_d_done" : "owner_i_done", 32'(own_d ? d_done : i_done), 32'd1);
        check("other_done", 32'(own_d ? i_done : d_done), 32'd0);
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("done_state", 32'(state), 32'(DONE));
        check("sb_owner_rdata", own_d ? d_rdata : i_rdata, exp_q.pop_front());
        check("i_rdata", i_rdata, m_i_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("err", 32'(err), 32'(m_err));
        @(negedge clk);
        check("done_single_pulse", 32'({i_done, d_done}), 32'd0);
        if (!hold) begin
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_quiet("reset");
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);

        // Both held continuously from reset: D, I, D, I, ...
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000;
        for (int n = 0; n < 6; n++) txn(0, 0, $urandom, 1);
        i_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
        check_quiet("after_fair");

        // Single I read, memory answers 3 cycles after mem_req rises.
        i_req = 1; i_wr = 0; i_addr = 32'h40; i_wdata = $urandom;
        txn(3, 0, 32'hDEADBEEF, 0);

        // D write leaves d_rdata untouched.
        d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
        txn(2, 0, $urandom, 0);
        d_wr = 0;

        // Stray mem_ready in IDLE.
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'hBADC0DE5;
        @(negedge clk);
        mem_ready = 0;
        check_quiet("stray_ready_1");
        @(negedge clk);
        check_quiet("stray_ready_2");

        // Timeout on an I read, then a normal D read.
        i_req = 1; i_wr = 0; i_addr = 32'h80;
        txn(0, 1, $urandom, 0);
        d_req = 1; d_wr = 0; d_addr = 32'h300;
        txn(1, 0, 32'hCAFEF00D, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of WAIT.
        i_req = 1; i_wr = 0; i_addr = 32'h500;
        repeat (2) @(negedge clk);
        check("pre_reset_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_state", 32'(state), 32'(IDLE));
        check("async_err", 32'(err), 32'd0);
        i_req = 0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_quiet("post_reset");
        end
        i_req = 1; i_addr = 32'h600; d_req = 1; d_addr = 32'h700;
        txn(1, 0, $urandom, 1);
        txn(0, 0, $urandom, 0);
        d_req = 0;

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_wr = 1'($urandom_range(0, 1));
                i_addr = $urandom; i_wdata = $urandom;
            end
            if (!d_req && ($urandom_range(0, 1) == 1 || !i_req)) begin
                d_req = 1; d_wr = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            txn($urandom_range(0, 4), $urandom_range(0, 9) == 0, $urandom, 0);
        end
        i_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
        check_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
